// File: rtl/ps2_arrow_decoder_if.sv
// ps2_arrow_decoder_if: arrow-key levels, press pulses and receive debug from the PS/2 decoder
interface ps2_arrow_decoder_if;
  logic up, down, left, right;
  logic up_press, down_press, left_press, right_press;
  logic [7:0] rx_byte;
  logic byte_valid, frame_err;
  modport master(output up, down, left, right, up_press, down_press, left_press, right_press, rx_byte, byte_valid, frame_err);
  modport slave(input up, down, left, right, up_press, down_press, left_press, right_press, rx_byte, byte_valid, frame_err);
endinterface

// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder: PS/2 frame receiver turning extended arrow scan codes into held levels and press pulses
module ps2_arrow_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic clk,
  input logic reset,
  input logic ps2_clk,
  input logic ps2_data,
  ps2_arrow_decoder_if.master kb
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sc, sd;
  logic [FW-1:0] fcnt;
  logic [WW-1:0] wd;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] sh, sh_n, rx;
  logic fclk, fclk_d, fall, s_data, timeout;
  logic par, par_n, bv, bv_n, fe, fe_n, ext, brk, term;
  logic [3:0] held, held_n, press, hit;
  assign s_data = sd[SYNC_STAGES-1];
  assign timeout = state != IDLE && wd == WW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (reset) begin
      sc <= '1;
      sd <= '1;
      fcnt <= '0;
      fclk <= 1'b1;
      fclk_d <= 1'b1;
      fall <= 1'b0;
    end else begin
      sc <= {sc[SYNC_STAGES-2:0], ps2_clk};
      sd <= {sd[SYNC_STAGES-2:0], ps2_data};
      fclk_d <= fclk;
      fall <= fclk_d & ~fclk;
      if (sc[SYNC_STAGES-1] == fclk) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fcnt <= '0;
        fclk <= ~fclk;
      end else fcnt <= fcnt + FW'(1);
    end
  end
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    sh_n = sh;
    par_n = par;
    bv_n = 1'b0;
    fe_n = 1'b0;
    if (fall)
      case (state)
        IDLE: begin
          state_n = s_data ? IDLE : DATA;
          bit_n = 3'd0;
          fe_n = s_data;
        end
        DATA: begin
          sh_n = {s_data, sh[7:1]};
          bit_n = bit_cnt + 3'd1;
          state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_n = s_data;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          bv_n = s_data & ^{sh, par};
          fe_n = ~(s_data & ^{sh, par});
        end
      endcase
    else if (timeout) begin
      state_n = IDLE;
      bit_n = 3'd0;
      fe_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      bv <= 1'b0;
      fe <= 1'b0;
      rx <= '0;
      wd <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      par <= par_n;
      bv <= bv_n;
      fe <= fe_n;
      rx <= bv_n ? sh : rx;
      wd <= (fall || state == IDLE || timeout) ? '0 : wd == WW'(TIMEOUT_CYCLES) ? wd : wd + WW'(1);
    end
  end
  // Bit order of hit/held: up, down, left, right
  assign hit = {rx == 8'h74, rx == 8'h6B, rx == 8'h72, rx == 8'h75};
  assign term = bv && rx != 8'hE0 && rx != 8'hF0;
  assign held_n = (term && ext) ? (brk ? held & ~hit : held | hit) : held;
  always_ff @(posedge clk) begin
    if (reset) begin
      held <= '0;
      press <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
    end else begin
      held <= held_n;
      press <= held_n & ~held;
      ext <= (fe || term) ? 1'b0 : (bv && rx == 8'hE0) ? 1'b1 : ext;
      brk <= (fe || term) ? 1'b0 : (bv && rx == 8'hF0) ? 1'b1 : brk;
    end
  end
  assign kb.up = held[0];
  assign kb.down = held[1];
  assign kb.left = held[2];
  assign kb.right = held[3];
  assign kb.up_press = press[0];
  assign kb.down_press = press[1];
  assign kb.left_press = press[2];
  assign kb.right_press = press[3];
  assign kb.rx_byte = rx;
  assign kb.byte_valid = bv;
  assign kb.frame_err = fe;
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// tb_ps2_arrow_decoder: directed PS/2 frame sequences checked with immediate assertions
module tb_ps2_arrow_decoder;
  localparam int H = 30;
  localparam int TO = 1000;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  int n_assert = 0, n_fail = 0;
  int cyc = 0, bv_n = 0, fe_n = 0, both = 0, bv_cyc = 0, fe_cyc = 0, last_fall = 0;
  int pr_n[4] = '{0, 0, 0, 0};
  int pr_cyc[4] = '{0, 0, 0, 0};
  always #5 clk = ~clk;
  ps2_arrow_decoder_if kb();
  ps2_arrow_decoder #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kb(kb)
  );
  always @(posedge clk) begin
    logic [3:0] pr;
    #1;
    cyc++;
    pr = {kb.right_press, kb.left_press, kb.down_press, kb.up_press};
    if (kb.byte_valid) begin bv_n++; bv_cyc = cyc; end
    if (kb.frame_err) begin fe_n++; fe_cyc = cyc; end
    if (kb.byte_valid && kb.frame_err) both++;
    for (int k = 0; k < 4; k++) if (pr[k]) begin pr_n[k]++; pr_cyc[k] = cyc; end
  end
  function automatic logic [31:0] outs();
    return {15'd0, kb.up, kb.down, kb.left, kb.right, kb.up_press, kb.down_press,
            kb.left_press, kb.right_press, kb.rx_byte, kb.byte_valid, kb.frame_err};
  endfunction
  function automatic logic [31:0] held();
    return {28'd0, kb.right, kb.left, kb.down, kb.up};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(1'b1);
    repeat (H) @(negedge clk);
  endtask
  initial begin
    int p, b, f, tf, d;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_outputs", outs(), 32'd0);
    p = pr_n[2];
    send_frame(8'hE0);
    send_frame(8'h6B);
    chk("left_held", 32'(kb.left), 32'd1);
    chk("left_press_count", pr_n[2] - p, 32'd1);
    chk("stop_to_byte_valid", bv_cyc - last_fall, 32'd12);
    chk("byte_valid_to_press", pr_cyc[2] - bv_cyc, 32'd1);
    chk("rx_byte_6b", 32'(kb.rx_byte), 32'h6B);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h6B);
    chk("left_released", held(), 32'd0);
    chk("release_no_press", pr_n[2] - p, 32'd1);
    p = pr_n[0];
    for (int r = 0; r < 3; r++) begin
      send_frame(8'hE0);
      send_frame(8'h75);
      chk("up_held_repeat", held(), 32'b0001);
    end
    chk("up_press_once", pr_n[0] - p, 32'd1);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    chk("up_released", held(), 32'd0);
    send_frame(8'h75);
    chk("keypad_75_ignored", held(), 32'd0);
    send_frame(8'hE0);
    b = bv_n;
    f = fe_n;
    send_frame(8'h74, 1'b1);
    chk("parity_frame_err", fe_n - f, 32'd1);
    chk("parity_no_byte_valid", bv_n - b, 32'd0);
    chk("parity_right_clear", held(), 32'd0);
    send_frame(8'hE0);
    send_frame(8'h74);
    chk("right_after_error", held(), 32'b1000);
    f = fe_n;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    tf = last_fall;
    for (int i = 0; i < TO + 200 && fe_n == f; i++) @(negedge clk);
    chk("timeout_frame_err", fe_n - f, 32'd1);
    d = fe_cyc - tf;
    chk("timeout_delay_window", 32'(d >= TO + 11 && d <= TO + 14), 32'd1);
    b = bv_n;
    send_frame(8'h1C);
    chk("after_timeout_byte_valid", bv_n - b, 32'd1);
    chk("after_timeout_rx_1c", 32'(kb.rx_byte), 32'h1C);
    chk("after_timeout_held", held(), 32'b1000);
    b = bv_n;
    f = fe_n;
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_no_pulses", (bv_n - b) + (fe_n - f), 32'd0);
    chk("glitch_held", held(), 32'b1000);
    f = fe_n;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midframe_reset_outputs", outs(), 32'd0);
    repeat (TO + 100) @(negedge clk);
    chk("midframe_reset_no_err", fe_n - f, 32'd0);
    send_frame(8'hE0);
    send_frame(8'h72);
    chk("down_after_reset", held(), 32'b0010);
    chk("rx_byte_72", 32'(kb.rx_byte), 32'h72);
    chk("pulse_exclusive", both, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
